// File: rtl/cmd_frame_rx_pkg.sv
// Shared definitions for the two-byte command frame receiver.
package cmd_frame_rx_pkg;

  localparam int unsigned CMD_WIDTH = 12;
  localparam int unsigned HALF_W    = CMD_WIDTH / 2;
  // HI byte carries bit HI_MARK set; bit LO_MARK must be clear in both bytes
  localparam int unsigned HI_MARK   = 7;
  localparam int unsigned LO_MARK   = 6;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

  function automatic int unsigned clks_per_bit(int unsigned f_hz, int unsigned baud);
    return (f_hz / baud < 4) ? 4 : f_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchroniser, bit FSM, byte and stop-error strobes.
module uart_rx_byte
  import cmd_frame_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxd,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_stop_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_sync1, r_sync2, r_prev, r_armed;
  logic [1:0]       r_settle;
  rx_state_t        r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_shift;
  logic             w_half, w_full;

  assign w_half = (r_cnt == HALF_M1);
  assign w_full = (r_cnt == FULL_M1);
  assign o_byte = r_shift;

  always_comb begin
    w_next       = r_state;
    o_byte_valid = 1'b0;
    o_stop_err   = 1'b0;
    case (r_state)
      RX_IDLE:  if (r_armed && r_prev && !r_sync2) w_next = RX_START;
      RX_START: if (w_half) w_next = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full && r_bitcnt == 3'd7) w_next = RX_STOP;
      RX_STOP: begin
        if (w_full) begin
          w_next       = RX_IDLE;
          o_byte_valid = r_sync2;
          o_stop_err   = !r_sync2;
        end
      end
      default:  w_next = RX_IDLE;
    endcase
  end

  // Edges are only trusted once the synchroniser has flushed its reset value
  // and the real line has been seen high, so a line held low through reset
  // cannot start a byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_prev   <= 1'b0;
      r_armed  <= 1'b0;
      r_settle <= '0;
      r_state  <= RX_IDLE;
      r_cnt    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
      r_armed <= r_armed | ((r_settle == 2'd2) & r_sync2);
      r_state <= w_next;
      if (r_state == RX_IDLE || w_next != r_state || w_full)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (r_state == RX_IDLE)
        r_bitcnt <= '0;
      else if (r_state == RX_DATA && w_full)
        r_bitcnt <= r_bitcnt + 3'd1;
      if (r_state == RX_DATA && w_full)
        r_shift <= {r_sync2, r_shift[7:1]};
    end
  end

endmodule

// File: rtl/cmd_frame_rx.sv
// Assembles HI/LO UART byte pairs into 12-bit command words with inter-byte timeout.
module cmd_frame_rx
  import cmd_frame_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic                 ExtClk,
  input  logic                 ExtResetn,
  input  logic                 UartRxD,
  output logic [CMD_WIDTH-1:0] DataOut,
  output logic                 DataOutValid,
  output logic                 FrameError
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned TMO_CLKS     = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TMO_W        = $clog2(TMO_CLKS + 1);

  logic [7:0]           w_byte;
  logic                 w_byte_valid, w_stop_err;
  logic                 w_is_hi, w_is_lo, w_tmo_hit;
  logic                 w_valid_d, w_err_d, w_latch_hi;
  asm_state_t           r_asm, w_asm_next;
  logic [HALF_W-1:0]    r_hi;
  logic [CMD_WIDTH-1:0] r_data;
  logic                 r_valid, r_err;
  logic [TMO_W-1:0]     r_tmo;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk       (ExtClk),
    .i_rst_n     (ExtResetn),
    .i_rxd       (UartRxD),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_stop_err  (w_stop_err)
  );

  assign w_is_hi   = w_byte[HI_MARK] & ~w_byte[LO_MARK];
  assign w_is_lo   = ~w_byte[HI_MARK] & ~w_byte[LO_MARK];
  assign w_tmo_hit = (r_asm == WAIT_LO) && (r_tmo == TMO_W'(TMO_CLKS - 1));

  always_comb begin
    w_asm_next = r_asm;
    w_valid_d  = 1'b0;
    w_err_d    = 1'b0;
    w_latch_hi = 1'b0;
    if (w_stop_err) begin
      w_err_d    = 1'b1;
      w_asm_next = WAIT_HI;
    end else if (w_byte_valid) begin
      case (r_asm)
        WAIT_HI: begin
          if (w_is_hi) begin
            w_latch_hi = 1'b1;
            w_asm_next = WAIT_LO;
          end else begin
            w_err_d = 1'b1;
          end
        end
        WAIT_LO: begin
          if (w_is_lo) begin
            w_valid_d  = 1'b1;
            w_asm_next = WAIT_HI;
          end else if (w_is_hi) begin
            w_err_d    = 1'b1;
            w_latch_hi = 1'b1;
          end else begin
            w_err_d    = 1'b1;
            w_asm_next = WAIT_HI;
          end
        end
        default: w_asm_next = WAIT_HI;
      endcase
    end else if (w_tmo_hit) begin
      w_err_d    = 1'b1;
      w_asm_next = WAIT_HI;
    end
  end

  // Timer starts at 1 on the HI sample cycle so the error lands exactly
  // TMO_CLKS clocks after that sample; re-latching a HI restarts it.
  always_ff @(posedge ExtClk or negedge ExtResetn) begin
    if (!ExtResetn) begin
      r_asm   <= WAIT_HI;
      r_hi    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_asm   <= w_asm_next;
      r_valid <= w_valid_d;
      r_err   <= w_err_d;
      if (w_latch_hi) r_hi <= w_byte[HALF_W-1:0];
      if (w_valid_d)  r_data <= {r_hi, w_byte[HALF_W-1:0]};
      if (w_latch_hi)
        r_tmo <= TMO_W'(1);
      else if (r_asm == WAIT_LO)
        r_tmo <= r_tmo + 1'b1;
      else
        r_tmo <= '0;
    end
  end

  assign DataOut      = r_data;
  assign DataOutValid = r_valid;
  assign FrameError   = r_err;

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Randomized self-checking bench for cmd_frame_rx against a frame-level reference model.
module tb_cmd_frame_rx;

  localparam int CPB     = 10;
  localparam int TMO_CYC = 320;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic [11:0] dout;
  logic        dv, fe;

  int          n_cmp = 0;
  int          n_bad = 0;
  longint      cyc = 0;

  logic [13:0] obs_q[$];
  longint      obs_t[$];
  logic [13:0] exp_q[$];

  bit          m_have_hi = 0;
  logic [5:0]  m_hi = '0;
  logic [11:0] m_last = '0;
  logic [11:0] prev_dout = '0;
  longint      lat_d = 98;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cmd_frame_rx #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .TIMEOUT_BITS(32)) dut (
    .ExtClk      (clk),
    .ExtResetn   (rst_n),
    .UartRxD     (rxd),
    .DataOut     (dout),
    .DataOutValid(dv),
    .FrameError  (fe)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_dout = dout;
    end else begin
      if (dv) begin obs_q.push_back({2'd1, dout}); obs_t.push_back(cyc); end
      if (fe) begin obs_q.push_back({2'd2, 12'h000}); obs_t.push_back(cyc); end
      if (dv && fe) chk("exclusive", 32'(dv & fe), 32'd0);
      if (!dv && dout !== prev_dout) chk("hold", 32'(dout), 32'(prev_dout));
      prev_dout = dout;
    end
  end

  task automatic drive_byte(input logic [7:0] b, input bit stop_ok, output longint t0);
    @(negedge clk);
    rxd = 1'b0;
    t0 = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) begin
      exp_q.push_back({2'd2, 12'h000});
      m_have_hi = 0;
    end else if (b[6]) begin
      exp_q.push_back({2'd2, 12'h000});
      m_have_hi = 0;
    end else if (b[7]) begin
      if (m_have_hi) exp_q.push_back({2'd2, 12'h000});
      m_have_hi = 1;
      m_hi = b[5:0];
    end else if (m_have_hi) begin
      m_last = {m_hi, b[5:0]};
      exp_q.push_back({2'd1, m_last});
      m_have_hi = 0;
    end else begin
      exp_q.push_back({2'd2, 12'h000});
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input int gap, output longint t0);
    model_byte(b, stop_ok);
    drive_byte(b, stop_ok, t0);
    repeat (gap * CPB) @(negedge clk);
  endtask

  task automatic compare(input string tag);
    int n;
    repeat (3 * CPB) @(negedge clk);
    chk($sformatf("%s.count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.ev%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    chk($sformatf("%s.dout", tag), 32'(dout), 32'(m_last));
    obs_q.delete();
    obs_t.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint t, t_lo, t_hi;
    logic [11:0] w;
    int sel;

    repeat (3) @(negedge clk);
    chk("rst.dout", 32'(dout), 32'h0);
    chk("rst.dv", 32'(dv), 32'h0);
    chk("rst.fe", 32'(fe), 32'h0);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // basic frame plus latency measurement
    send(8'h80, 1, 0, t);
    send(8'h04, 1, 0, t_lo);
    repeat (3 * CPB) @(negedge clk);
    if (obs_t.size() > 0) lat_d = obs_t[0] - t_lo;
    chk("latency.range", 32'(lat_d >= 95 && lat_d <= 101), 32'd1);
    compare("f004");

    send(8'hBF, 1, 0, t); send(8'h3F, 1, 1, t);
    compare("fFFF");
    send(8'h80, 1, 0, t); send(8'h02, 1, 1, t);
    compare("f002");

    send(8'h05, 1, 1, t);
    send(8'h80, 1, 0, t); send(8'h01, 1, 1, t);
    compare("strayLO");

    send(8'h81, 1, 0, t); send(8'h82, 1, 0, t); send(8'h03, 1, 1, t);
    compare("reHI");

    // inter-byte timeout
    send(8'h80, 1, 0, t_hi);
    repeat (400) @(negedge clk);
    exp_q.push_back({2'd2, 12'h000});
    m_have_hi = 0;
    if (obs_t.size() > 0)
      chk("tmo.cycle", 32'(obs_t[0] - t_hi), 32'(lat_d + TMO_CYC - 1));
    else
      chk("tmo.seen", 32'd0, 32'd1);
    compare("timeout");
    send(8'h03, 1, 1, t);
    compare("postTmoLO");

    send(8'h80, 1, 0, t); send(8'h05, 0, 2, t);
    compare("stopErr");

    // reset in the middle of a HI byte, line held low across release
    send(8'h85, 1, 0, t); send(8'h05, 1, 1, t);
    compare("preRst");
    @(negedge clk);
    rxd = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midRst.dout", 32'(dout), 32'h0);
    chk("midRst.dv", 32'(dv), 32'h0);
    chk("midRst.fe", 32'(fe), 32'h0);
    rst_n = 1'b1;
    m_last = '0;
    m_have_hi = 0;
    repeat (3 * CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    compare("postRstIdle");
    send(8'h80, 1, 0, t); send(8'h2A, 1, 1, t);
    compare("postRstFrame");

    // randomized mix of good frames and malformed traffic
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      w = 12'($urandom);
      case (sel)
        6: send({2'b00, w[5:0]}, 1, $urandom_range(0, 2), t);
        7: begin
          send({2'b10, w[11:6]}, 1, $urandom_range(0, 2), t);
          send({2'b10, w[5:0]}, 1, $urandom_range(0, 2), t);
        end
        8: send({w[7], 1'b1, w[5:0]}, 1, $urandom_range(0, 2), t);
        9: send(w[7:0], 0, $urandom_range(1, 2), t);
        default: begin
          send({2'b10, w[11:6]}, 1, $urandom_range(0, 2), t);
          send({2'b00, w[5:0]}, 1, $urandom_range(0, 2), t);
        end
      endcase
    end
    compare("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmd_frame_rx.md
CMD_FRAME_RX -- requirements
Module: cmd_frame_rx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50000000, ExtClk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer divide), minimum 4.
REQ-003 Parameter TIMEOUT_BITS, default 32, inter-byte timeout in bit periods.
REQ-004 ExtClk  input  1  sole clock, rising edge.
REQ-005 ExtResetn  input  1  reset, asynchronous assert, active-low.
REQ-006 UartRxD  input  1  asynchronous UART line from host, idle high, 8N1, LSB first.
REQ-007 DataOut  output  12  decoded command word for the mode-control consumer.
REQ-008 DataOutValid  output  1  one-cycle strobe qualifying DataOut.
REQ-009 FrameError  output  1  one-cycle strobe on any rejected byte or frame.

Function
REQ-010 UartRxD SHALL pass through a 2-flop synchroniser before any use; synchroniser resets to 1.
REQ-011 Byte receiver states SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE -> START on synchronised falling edge (1 then 0); bit counter cleared.
REQ-013 START: at CLKS_PER_BIT/2 clocks, line 0 -> DATA; line 1 -> IDLE (glitch), no error strobe.
REQ-014 DATA: sample every CLKS_PER_BIT clocks, 8 samples LSB first, then -> STOP.
REQ-015 STOP: sample after CLKS_PER_BIT; 1 -> byte accepted; 0 -> FrameError strobe, byte discarded; both -> IDLE.
REQ-016 Frame = two bytes: HI byte bit7=1, bit6=0, bits5:0 = DataOut[11:6]; LO byte bit7=0, bit6=0, bits5:0 = DataOut[5:0].
REQ-017 Assembler states SHALL be WAIT_HI, WAIT_LO.
REQ-018 WAIT_HI: HI byte -> latch 6 bits, -> WAIT_LO; LO byte or bit6=1 -> FrameError, stay.
REQ-019 WAIT_LO: LO byte with bit6=0 -> DataOut updated, DataOutValid high exactly 1 cycle, -> WAIT_HI.
REQ-020 WAIT_LO: new HI byte -> FrameError, re-latch new high bits, stay WAIT_LO (resynchronise on latest HI).
REQ-021 WAIT_LO: bit6=1 byte or stop-bit error -> FrameError, -> WAIT_HI.
REQ-022 WAIT_LO: no byte accepted within TIMEOUT_BITS*CLKS_PER_BIT clocks of HI stop sample -> FrameError, -> WAIT_HI; timer counts only in WAIT_LO.
REQ-023 Latency: DataOutValid SHALL assert 1 clock after the LO stop-bit sample cycle.
REQ-024 DataOut SHALL hold its last value between strobes; changes only with DataOutValid.
REQ-025 DataOutValid and FrameError SHALL never assert in the same cycle.
REQ-026 No value filtering: any 12-bit word including 0xFFF SHALL be delivered; decode belongs to the consumer.

Reset
REQ-027 ExtResetn low: DataOut=12'h000, DataOutValid=0, FrameError=0, receiver IDLE, assembler WAIT_HI, counters 0.
REQ-028 Reset mid-byte or mid-frame SHALL discard partial data with no strobe after release.
REQ-029 After release, a line already low SHALL NOT start a byte until a 1->0 edge is seen.

Structure
REQ-030 Shared package holds HI_MARK/LO_MARK bit positions, receiver and assembler state encodings, CMD_WIDTH=12.
REQ-031 Byte receiver SHALL be sub-module uart_rx_byte (synchroniser, bit FSM, byte strobe, stop-error strobe); assembler and timeout in cmd_frame_rx.

Verification (CLK_FREQ_HZ=1000000, BAUD=100000, CLKS_PER_BIT=10, TIMEOUT_BITS=32)
REQ-032 Bytes 0x80, 0x04 -> DataOutValid one cycle, DataOut=0x004, no FrameError.
REQ-033 Bytes 0xBF, 0x3F -> DataOut=0xFFF; then 0x80, 0x02 -> DataOut=0x002.
REQ-034 Byte 0x05 in WAIT_HI -> FrameError one cycle, no DataOutValid; following 0x80, 0x01 -> DataOut=0x001.
REQ-035 0x81 then 0x82 then 0x03 -> FrameError at 0x82, then DataOut=0x083.
REQ-036 0x80 then idle 400 clocks -> FrameError at clock 320 after HI stop sample; next 0x03 alone -> FrameError.
REQ-037 Stop bit forced 0 on LO byte -> FrameError, no DataOutValid; ExtResetn pulse mid-HI byte -> outputs 0, next valid frame decodes.
